// File: rtl/regfile_param_if.sv
// Register-file access bundle: one write port and two read ports.
// Parameters must match those of the regfile_param instance it is bound to.
interface regfile_param_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
);
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [WIDTH-1:0]  wdata;
    logic [ADDR_W-1:0] raddr_a;
    logic [ADDR_W-1:0] raddr_b;
    logic [WIDTH-1:0]  rdata_a;
    logic [WIDTH-1:0]  rdata_b;

    modport master (
        output we, waddr, wdata, raddr_a, raddr_b,
        input  rdata_a, rdata_b
    );

    modport slave (
        input  we, waddr, wdata, raddr_a, raddr_b,
        output rdata_a, rdata_b
    );
endinterface

// File: rtl/regfile_param.sv
// DEPTH x WIDTH register file: one write port, two independent read ports, synchronous clear,
// optional hardwired-zero entry 0, write-to-read bypass and registered read.
module regfile_param #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1,
    parameter bit READ_REG = 1'b0
) (
    input logic             clock,
    input logic             clr,
    regfile_param_if.slave  bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic              w_wr_en;
    logic              w_wr_live;
    logic [ADDR_W-1:0] w_raddr [2];
    logic [WIDTH-1:0]  w_sel   [2];

    assign w_wr_live  = bus.we && !clr;
    assign w_wr_en    = w_wr_live && !(ZERO_REG && (bus.waddr == '0));
    assign w_raddr[0] = bus.raddr_a;
    assign w_raddr[1] = bus.raddr_b;

    always_ff @(posedge clock) begin
        if (clr) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[bus.waddr] <= bus.wdata;
        end
    end

    // Zero-register masking is applied last so it also overrides a bypassed write to entry 0.
    always_comb begin
        for (int unsigned p = 0; p < 2; p++) begin
            w_sel[p] = r_mem[w_raddr[p]];
            if (BYPASS && w_wr_live && (w_raddr[p] == bus.waddr)) begin
                w_sel[p] = bus.wdata;
            end
            if (ZERO_REG && (w_raddr[p] == '0)) begin
                w_sel[p] = '0;
            end
        end
    end

    generate
        if (READ_REG) begin : g_rd_reg
            logic [WIDTH-1:0] r_rdata [2];

            always_ff @(posedge clock) begin
                for (int unsigned p = 0; p < 2; p++) begin
                    r_rdata[p] <= clr ? '0 : w_sel[p];
                end
            end

            assign bus.rdata_a = r_rdata[0];
            assign bus.rdata_b = r_rdata[1];
        end else begin : g_rd_comb
            assign bus.rdata_a = w_sel[0];
            assign bus.rdata_b = w_sel[1];
        end
    endgenerate
endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: a default build (zero reg, bypass, combinational read) and a
// registered-read build without bypass or zero reg, both fed identical stimulus.
module tb_regfile_param;
    logic        clock = 1'b0;
    logic        s_clr = 1'b1;
    logic        s_we = 1'b0;
    logic [4:0]  s_waddr = '0;
    logic [31:0] s_wdata = '0;
    logic [4:0]  s_ra = '0;
    logic [4:0]  s_rb = '0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    regfile_param_if #(.WIDTH(32), .ADDR_W(5)) bus0 ();
    regfile_param_if #(.WIDTH(32), .ADDR_W(5)) bus1 ();

    assign bus0.we = s_we;       assign bus1.we = s_we;
    assign bus0.waddr = s_waddr; assign bus1.waddr = s_waddr;
    assign bus0.wdata = s_wdata; assign bus1.wdata = s_wdata;
    assign bus0.raddr_a = s_ra;  assign bus1.raddr_a = s_ra;
    assign bus0.raddr_b = s_rb;  assign bus1.raddr_b = s_rb;

    regfile_param #(
        .WIDTH(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1), .READ_REG(1'b0)
    ) u_dut0 (
        .clock(clock), .clr(s_clr), .bus(bus0.slave)
    );

    regfile_param #(
        .WIDTH(32), .ADDR_W(5), .ZERO_REG(1'b0), .BYPASS(1'b0), .READ_REG(1'b1)
    ) u_dut1 (
        .clock(clock), .clr(s_clr), .bus(bus1.slave)
    );

    // Reference contents of each build plus the registered-read expectations of build 1.
    logic [31:0] m0 [32];
    logic [31:0] m1 [32];
    logic [31:0] e1_a = '0;
    logic [31:0] e1_b = '0;
    bit          model_valid = 1'b0;

    function automatic logic [31:0] read0(input logic [4:0] ra);
        if (ra == 5'd0) return 32'h0;
        if (s_we && !s_clr && ra == s_waddr) return s_wdata;
        return m0[ra];
    endfunction

    always @(posedge clock) begin
        e1_a = s_clr ? 32'h0 : m1[s_ra];
        e1_b = s_clr ? 32'h0 : m1[s_rb];
        if (s_clr) begin
            for (int i = 0; i < 32; i++) begin
                m0[i] = 32'h0;
                m1[i] = 32'h0;
            end
            model_valid = 1'b1;
        end else if (s_we) begin
            if (s_waddr != 5'd0) m0[s_waddr] = s_wdata;
            m1[s_waddr] = s_wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %08h expected %08h", name, $time, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (model_valid) begin
            check("model_b0_a", bus0.rdata_a, read0(s_ra));
            check("model_b0_b", bus0.rdata_b, read0(s_rb));
            check("model_b1_a", bus1.rdata_a, e1_a);
            check("model_b1_b", bus1.rdata_b, e1_b);
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    initial begin
        // Reset and full-range read of zeros
        s_clr = 1'b1;
        step();
        step();
        s_clr = 1'b0;
        for (int a = 0; a < 32; a++) begin
            s_ra = 5'(a);
            s_rb = 5'(31 - a);
            #1;
            check("reset_a", bus0.rdata_a, 32'h0);
            check("reset_b", bus0.rdata_b, 32'h0);
        end
        step();
        check("reset_rr_a", bus1.rdata_a, 32'h0);
        check("reset_rr_b", bus1.rdata_b, 32'h0);

        // Write / readback, then we=0 must not disturb
        s_we = 1'b1; s_waddr = 5'd3; s_wdata = 32'hA5A5A5A5;
        step();
        s_waddr = 5'd7; s_wdata = 32'h5A5A5A5A;
        step();
        s_we = 1'b0; s_wdata = 32'hFFFFFFFF; s_ra = 5'd3; s_rb = 5'd7;
        #1;
        check("wr_rd_a", bus0.rdata_a, 32'hA5A5A5A5);
        check("wr_rd_b", bus0.rdata_b, 32'h5A5A5A5A);
        step();
        check("we0_hold_a", bus0.rdata_a, 32'hA5A5A5A5);
        check("we0_hold_b", bus0.rdata_b, 32'h5A5A5A5A);
        check("rr_wr_rd_a", bus1.rdata_a, 32'hA5A5A5A5);
        check("rr_wr_rd_b", bus1.rdata_b, 32'h5A5A5A5A);

        // Zero register, including same-cycle bypass
        s_we = 1'b1; s_waddr = 5'd0; s_wdata = 32'hFFFFFFFF; s_ra = 5'd0;
        #1;
        check("zero_bypass", bus0.rdata_a, 32'h0);
        step();
        s_we = 1'b0;
        #1;
        check("zero_read", bus0.rdata_a, 32'h0);

        // Bypass vs. no-bypass registered build
        s_we = 1'b1; s_waddr = 5'd5; s_wdata = 32'h00000011;
        step();
        s_wdata = 32'h00000022; s_ra = 5'd5;
        #1;
        check("bypass_a", bus0.rdata_a, 32'h00000022);
        step();
        check("nobyp_old", bus1.rdata_a, 32'h00000011);
        s_we = 1'b0;
        step();
        check("nobyp_new", bus1.rdata_a, 32'h00000022);

        // clr beats we
        s_we = 1'b1; s_waddr = 5'd9; s_wdata = 32'h12345678;
        step();
        s_clr = 1'b1; s_wdata = 32'hDEADBEEF;
        step();
        s_clr = 1'b0; s_we = 1'b0; s_ra = 5'd9;
        #1;
        check("clr_wins", bus0.rdata_a, 32'h0);
        step();
        check("clr_wins_rr", bus1.rdata_a, 32'h0);

        // Registered read latency and clr of read registers
        s_we = 1'b1; s_waddr = 5'd4; s_wdata = 32'hCAFEF00D;
        step();
        s_we = 1'b0; s_ra = 5'd4;
        #1;
        check("rr_before_edge", bus1.rdata_a, 32'h0);
        step();
        check("rr_latency", bus1.rdata_a, 32'hCAFEF00D);
        s_clr = 1'b1;
        step();
        check("rr_clr", bus1.rdata_a, 32'h0);
        s_clr = 1'b0;

        // Random traffic, read addresses often colliding with the write address
        for (int i = 0; i < 3000; i++) begin
            s_clr   = ($urandom_range(0, 63) == 0);
            s_we    = 1'($urandom_range(0, 1));
            s_waddr = 5'($urandom_range(0, 31));
            s_wdata = $urandom;
            s_ra    = ($urandom_range(0, 2) == 0) ? s_waddr : 5'($urandom_range(0, 31));
            s_rb    = ($urandom_range(0, 2) == 0) ? s_waddr : 5'($urandom_range(0, 31));
            step();
        end
        s_we = 1'b0;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
